// File: rtl/bp_pkg.sv
// Shared types for the branch resolution controller: FIFO entry layout,
// controller state encoding and a saturating counter helper.
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } brc_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } brc_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/brc_entry_fifo.sv
// In-order circular store of predicted branches. Pointers wrap modulo DEPTH;
// clear empties the store and takes priority over push and pop.
module brc_entry_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  brc_entry_t                   push_data,
    input  logic                         pop,
    input  logic                         clear,
    output brc_entry_t                   head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    brc_entry_t        mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    // NOTE: storage has no reset; count and pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks in-flight predicted branches, resolves them oldest-first, drives
// predictor updates and redirects. Optional statistics: define BRC_STATS_EN.
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         alloc_valid,
    input  logic [31:0]                  alloc_pc,
    input  logic                         alloc_pred,
    output logic                         alloc_ready,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic                         flush,
    output logic                         pred_update,
    output logic [31:0]                  pred_pc,
    output logic                         pred_actual_taken,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  stat_branches,
    output logic [15:0]                  stat_mispredicts
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    brc_state_e  state;
    brc_state_e  state_next;
    brc_entry_t  head_entry;
    brc_entry_t  new_entry;
    logic        resolve_fire;
    logic        resolve_mis;
    logic        alloc_fire;
    logic        fifo_clear;

    // Ready depends only on registered state so fetch never sees a combinational path from resolve.
    assign alloc_ready  = (state == RUN) && (count < FULL_COUNT);

    assign resolve_fire = resolve_valid && (count != '0);
    assign resolve_mis  = resolve_fire && (resolve_taken != head_entry.pred);
    assign fifo_clear   = flush || resolve_mis;
    assign alloc_fire   = alloc_valid && alloc_ready && !fifo_clear;
    assign new_entry    = '{pc: alloc_pc, pred: alloc_pred};

    brc_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (alloc_fire),
        .push_data (new_entry),
        .pop       (resolve_fire),
        .clear     (fifo_clear),
        .head_data (head_entry),
        .count     (count)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = RUN;
        if (!flush && resolve_mis) begin
            state_next = RECOVER;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= RUN;
            pred_update       <= 1'b0;
            mispredict        <= 1'b0;
            pred_pc           <= '0;
            pred_actual_taken <= 1'b0;
        end else begin
            state       <= state_next;
            pred_update <= resolve_fire;
            mispredict  <= resolve_mis;
            if (resolve_fire) begin
                pred_pc           <= head_entry.pc;
                pred_actual_taken <= resolve_taken;
            end
        end
    end

`ifdef BRC_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve_fire) begin
                stat_branches <= sat_inc16(stat_branches);
            end
            if (resolve_mis) begin
                stat_mispredicts <= sat_inc16(stat_mispredicts);
            end
        end
    end
`else
    assign stat_branches    = 16'h0000;
    assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: stimulus pushes expected
// predictor updates, a negedge monitor pops and compares them.
module tb_branch_resolve_ctrl;
    import bp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic        alloc_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        pred_update;
    logic [31:0] pred_pc;
    logic        pred_actual_taken;
    logic        mispredict;
    logic [2:0]  count;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    brc_entry_t  mq[$];
    logic        st_recover;
    logic [15:0] exp_br;
    logic [15:0] exp_mis;
    logic [31:0] last_pc;
    logic        last_taken;
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DEPTH(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .alloc_valid       (alloc_valid),
        .alloc_pc          (alloc_pc),
        .alloc_pred        (alloc_pred),
        .alloc_ready       (alloc_ready),
        .resolve_valid     (resolve_valid),
        .resolve_taken     (resolve_taken),
        .flush             (flush),
        .pred_update       (pred_update),
        .pred_pc           (pred_pc),
        .pred_actual_taken (pred_actual_taken),
        .mispredict        (mispredict),
        .count             (count),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_stats();
`ifdef BRC_STATS_EN
        check("stat_branches", stat_branches, exp_br);
        check("stat_mispredicts", stat_mispredicts, exp_mis);
`else
        check("stat_branches_tied", stat_branches, 32'h0);
        check("stat_mispredicts_tied", stat_mispredicts, 32'h0);
`endif
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic av, input logic [31:0] pc, input logic pr,
                         input logic rv, input logic rt, input logic fl);
        logic       exp_ready;
        logic       rfire;
        logic       mis;
        brc_entry_t h;
        alloc_valid   = av;
        alloc_pc      = pc;
        alloc_pred    = pr;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        exp_ready = !st_recover && (mq.size() < 4);
        #1;
        check("alloc_ready", alloc_ready, exp_ready);
        rfire = rv && (mq.size() > 0);
        mis   = 1'b0;
        if (rfire) begin
            h   = mq.pop_front();
            mis = (rt != h.pred);
            sb.push_back('{pc: h.pc, taken: rt, mis: mis});
            if (exp_br != 16'hFFFF) exp_br++;
            if (mis && exp_mis != 16'hFFFF) exp_mis++;
        end
        if (fl || mis) mq.delete();
        else if (av && exp_ready) mq.push_back('{pc: pc, pred: pr});
        st_recover = !fl && mis;
        @(posedge clk);
        #1;
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
        check("count", count, mq.size());
        check_stats();
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every update must match the oldest expected one; outputs hold otherwise.
    initial begin
        last_pc    = '0;
        last_taken = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_pc    = '0;
                last_taken = 1'b0;
            end else if (pred_update) begin
                if (sb.size() == 0) begin
                    check("unexpected_update", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pred_pc", pred_pc, e.pc);
                    check("pred_actual_taken", pred_actual_taken, e.taken);
                    check("mispredict", mispredict, e.mis);
                    last_pc    = e.pc;
                    last_taken = e.taken;
                end
            end else begin
                check("mispredict_idle", mispredict, 32'h0);
                check("pred_pc_hold", pred_pc, last_pc);
                check("pred_taken_hold", pred_actual_taken, last_taken);
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        alloc_valid   = 1'b0;
        alloc_pc      = '0;
        alloc_pred    = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
        st_recover    = 1'b0;
        exp_br        = '0;
        exp_mis       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_count", count, 32'h0);
        check("reset_alloc_ready", alloc_ready, 32'h1);
        check("reset_pred_update", pred_update, 32'h0);
        check("reset_mispredict", mispredict, 32'h0);
        check("reset_pred_pc", pred_pc, 32'h0);
        check_stats();
        reset_n = 1'b1;

        // Basic correct prediction.
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0);
        check("basic_count", count, 32'h0);
        idle();

        // Resolve on empty is a no-op; a same-cycle alloc still lands.
        cycle(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h150, 1'b1, 1'b1, 1'b0, 1'b0);
        check("empty_resolve_alloc_count", count, 32'h1);
        cycle(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0);
        idle();

        // Full with simultaneous alloc and resolve: alloc rejected.
        cycle(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h210, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h220, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h230, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h240, 1'b1, 1'b1, 1'b1, 1'b0);
        check("full_reject_count", count, 32'h3);

        // Flush alone empties the FIFO.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("flush_count", count, 32'h0);

        // Mispredict squashes, drops the same-cycle alloc, one RECOVER cycle.
        cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h310, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h320, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h330, 1'b1, 1'b1, 1'b1, 1'b0);
        check("recover_alloc_ready", alloc_ready, 32'h0);
        cycle(1'b1, 32'h340, 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_recover_alloc_ready", alloc_ready, 32'h1);
        idle();

        // Flush with a matching resolve: one update, FIFO empty.
        cycle(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h410, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h420, 1'b1, 1'b1, 1'b1, 1'b1);
        check("flush_resolve_count", count, 32'h0);
        idle();

        // Flush with a mispredicting resolve: pulse emitted, no RECOVER.
        cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1);
        check("flush_mis_alloc_ready", alloc_ready, 32'h1);
        idle();

        // Wrap-around: ten overlapped alloc/resolve pairs.
        cycle(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            logic [31:0] iv;
            iv = i;
            cycle(1'b1, 32'h600 + iv * 4, iv[0], 1'b1, ~iv[0], 1'b0);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_count", count, 32'h0);
        idle();

        // Reset mid-operation discards in-flight entries silently.
        cycle(1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h710, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        st_recover = 1'b0;
        exp_br     = '0;
        exp_mis    = '0;
        check("midreset_count", count, 32'h0);
        check("midreset_pred_pc", pred_pc, 32'h0);
        reset_n = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        idle();

        check("scoreboard_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning max in-flight predicted branches; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port alloc_valid, input, 1, fetch presents a predicted branch.
REQ-005 SHALL have port alloc_pc, input, 32, PC of that branch.
REQ-006 SHALL have port alloc_pred, input, 1, predictor's taken prediction for that branch.
REQ-007 SHALL have port alloc_ready, output, 1, entry available; the branch is accepted when alloc_valid && alloc_ready.
REQ-008 SHALL have port resolve_valid, input, 1, execute resolves the oldest branch.
REQ-009 SHALL have port resolve_taken, input, 1, actual outcome of that branch.
REQ-010 SHALL have port flush, input, 1, external pipeline flush.
REQ-011 SHALL have port pred_update, output, 1, update strobe to the predictor.
REQ-012 SHALL have port pred_pc, output, 32, PC for the predictor update.
REQ-013 SHALL have port pred_actual_taken, output, 1, outcome for the predictor update.
REQ-014 SHALL have port mispredict, output, 1, redirect pulse.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1), number of occupied entries.
REQ-016 SHALL have port stat_branches, output, 16, resolved-branch count.
REQ-017 SHALL have port stat_mispredicts, output, 16, mispredict count.

Function
REQ-018 SHALL hold entries {pc, pred} in an in-order circular FIFO; head and tail pointers wrap modulo DEPTH.
REQ-019 SHALL use an FSM with states RUN and RECOVER; reset enters RUN.
REQ-020 SHALL drive alloc_ready = (state==RUN) && (count<DEPTH), combinationally from registered state only.
REQ-021 SHALL, when full with a same-cycle resolve, not accept the alloc that cycle; alloc_ready is not recomputed from resolve.
REQ-022 SHALL treat resolve_valid with count==0 as a no-op: no update, no pulse, and a same-cycle alloc is still accepted.
REQ-023 SHALL, on a valid resolve, pop the head entry and assert pred_update, pred_pc = entry pc and pred_actual_taken = resolve_taken for exactly one cycle, on the next clock edge (1-cycle latency).
REQ-024 SHALL assert mispredict for one cycle, aligned with pred_update, when resolve_taken != entry pred.
REQ-025 SHALL, on a mispredicting resolve, squash all remaining entries (count becomes 0) and enter RECOVER for exactly one cycle, then return to RUN.
REQ-026 SHALL drop any alloc in the cycle of a mispredicting resolve, since alloc_ready is already evaluated; the entry is squashed.
REQ-027 SHALL, on flush, clear the FIFO (count becomes 0, pointers equal) and enter RUN.
REQ-028 SHALL still process a resolve that coincides with flush, emitting its update and mispredict, while the alloc that cycle is discarded.
REQ-029 SHALL hold pred_pc and pred_actual_taken at their last value when pred_update is low.

Reset
REQ-030 SHALL, on reset_n low at a clock edge, set state=RUN, count=0, pointers=0, pred_update=0, mispredict=0, pred_pc=0, pred_actual_taken=0 and stats=0.
REQ-031 SHALL, when reset occurs mid-operation, discard all in-flight entries without emitting updates.

Configuration
REQ-032 SHALL, with macro BRC_STATS_EN defined, make stat_branches count every valid resolve and stat_mispredicts count every mispredict, both saturating at 16'hFFFF.
REQ-033 SHALL, without BRC_STATS_EN, keep both stat ports present and tied to 0, with no counter flops.

Structure
REQ-034 SHALL place typedef brc_entry_t {logic [31:0] pc; logic pred;} and enum brc_state_e {RUN, RECOVER} in shared package bp_pkg.
REQ-035 SHALL implement storage and pointers in one sub-module brc_entry_fifo; the FSM, update and stats logic stay in the top.

Verification
REQ-036 SHALL cover: alloc pc=0x100 pred=1, then resolve taken=1 -> next cycle pred_update=1, pred_pc=0x100, pred_actual_taken=1, mispredict=0, count=0.
REQ-037 SHALL cover: fill 4 entries, then assert alloc+resolve together while full -> alloc rejected, count=3, oldest pc updated.
REQ-038 SHALL cover: 3 entries with head pred=0, resolve taken=1 -> mispredict=1, count=0, alloc_ready=0 for one cycle, then 1.
REQ-039 SHALL cover: resolve_valid with count=0 -> no pred_update, no mispredict, and stat_branches unchanged.
REQ-040 SHALL cover: 2 entries, flush with resolve (taken matches) -> one pred_update, count=0, and stat_branches +1 when BRC_STATS_EN is defined.
REQ-041 SHALL cover: wrap-around with 10 alloc/resolve pairs at DEPTH=4 -> updates in FIFO order with correct PCs.
